maindec_mc: RTL and testbench

Multicycle control FSM for the LEGv8 core. It replaces the single-cycle main decoder with a registered sequencer that spans the FETCH, DECODE, EXEC, MEM, WB and BRANCH steps. It adds CBNZ, B and ADDI support, and wait-state handshakes to instruction and data memory. It also keeps a retired-instruction counter. It sits between the instruction register and the datapath muxes, register file and memories.

---
 rtl/maindec_pkg.sv | 37 +++
 rtl/maindec_opclass_dec.sv | 22 ++
 rtl/maindec_mc.sv | 138 +++++++++++++
 tb/tb_maindec_mc.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/maindec_pkg.sv
// maindec_pkg: shared states, instruction classes, opcode patterns and ALUOp codes
// for the multicycle LEGv8 control sequencer.
package maindec_pkg;
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC   = 4'd2,
        MEMRD  = 4'd3,
        MEMWR  = 4'd4,
        WB     = 4'd5,
        BRANCH = 4'd6,
        SKIP   = 4'd7,
        EXC    = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        CL_INVALID, CL_RTYPE, CL_ADDI, CL_LOAD, CL_STORE,
        CL_CBZ, CL_CBNZ, CL_B, CL_MOVZ
    } class_t;

    // '?' bits are wildcards when matched with casez
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_ADDI = 11'b1001000100?;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100???;
    localparam logic [10:0] OP_CBNZ = 11'b10110101???;
    localparam logic [10:0] OP_B    = 11'b000101?????;
    localparam logic [10:0] OP_MOVZ = 11'b110100101??;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
endpackage

// File: rtl/maindec_opclass_dec.sv
// opclass_dec: combinational opcode -> instruction class classifier,
// shared by the multicycle and pipelined decoders.
module opclass_dec
    import maindec_pkg::*;
(
    input  logic [10:0] i_op,
    output class_t      o_class
);
    always_comb begin
        casez (i_op)
            OP_ADD, OP_SUB, OP_AND, OP_ORR: o_class = CL_RTYPE;
            OP_ADDI: o_class = CL_ADDI;
            OP_LDUR: o_class = CL_LOAD;
            OP_STUR: o_class = CL_STORE;
            OP_CBZ:  o_class = CL_CBZ;
            OP_CBNZ: o_class = CL_CBNZ;
            OP_B:    o_class = CL_B;
            OP_MOVZ: o_class = CL_MOVZ;
            default: o_class = CL_INVALID;
        endcase
    end
endmodule

// File: rtl/maindec_mc.sv
// maindec_mc: multicycle LEGv8 control FSM with memory wait states and retire counter.
// Define MAINDEC_EXC_EN to trap invalid opcodes in a sticky EXC state with an exc output.
module maindec_mc
    import maindec_pkg::*;
#(
    parameter int OP_W  = 11,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  Op,
    input  logic             Zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             Reg2Loc,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [1:0]       ALUOp,
    output logic             imem_req,
    output logic [CNT_W-1:0] instr_count,
`ifdef MAINDEC_EXC_EN
    output logic             exc,
`endif
    output logic [3:0]       state_o
);
`ifdef MAINDEC_EXC_EN
    localparam state_t INV_NEXT = EXC;
`else
    localparam state_t INV_NEXT = SKIP;
`endif

    state_t           r_state, w_next;
    class_t           r_class, w_class;
    logic [CNT_W-1:0] r_count;
    logic             w_retire;

    opclass_dec u_opclass_dec (
        .i_op    (Op[10:0]),
        .o_class (w_class)
    );

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:  w_next = imem_ready ? DECODE : FETCH;
            DECODE: w_next = (w_class == CL_CBZ || w_class == CL_CBNZ || w_class == CL_B) ? BRANCH :
                             (w_class == CL_INVALID) ? INV_NEXT : EXEC;
            EXEC:   w_next = (r_class == CL_LOAD) ? MEMRD : (r_class == CL_STORE) ? MEMWR : WB;
            MEMRD:  w_next = dmem_ready ? WB : MEMRD;
            MEMWR:  w_next = dmem_ready ? FETCH : MEMWR;
            EXC:    w_next = EXC;
            default: w_next = FETCH;
        endcase
    end

    assign w_retire = (r_state == WB) || (r_state == BRANCH) || (r_state == MEMWR && dmem_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH;
            r_class <= CL_INVALID;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE) r_class <= w_class;
            if (w_retire) r_count <= r_count + CNT_W'(1);
        end
    end

    // Controls are gated by reset so nothing leaks out while the core is held
    always_comb begin
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        Reg2Loc  = 1'b0;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALUOp    = ALUOP_ADD;
        imem_req = 1'b0;
`ifdef MAINDEC_EXC_EN
        exc      = 1'b0;
`endif
        if (reset) begin
            case (r_state)
                FETCH: begin
                    imem_req = 1'b1;
                    IRWrite  = imem_ready;
                end
                EXEC: begin
                    ALUOp   = (r_class == CL_RTYPE) ? ALUOP_RTYPE :
                              (r_class == CL_MOVZ) ? ALUOP_PASSB : ALUOP_ADD;
                    ALUSrc  = (r_class == CL_ADDI) || (r_class == CL_LOAD) ||
                              (r_class == CL_STORE) || (r_class == CL_MOVZ);
                    Reg2Loc = (r_class == CL_STORE);
                end
                MEMRD: begin
                    MemRead = 1'b1;
                    ALUSrc  = 1'b1;
                end
                MEMWR: begin
                    MemWrite = 1'b1;
                    Reg2Loc  = 1'b1;
                    ALUSrc   = 1'b1;
                    PCWrite  = dmem_ready;
                end
                WB: begin
                    RegWrite = 1'b1;
                    PCWrite  = 1'b1;
                    MemtoReg = (r_class == CL_LOAD);
                end
                BRANCH: begin
                    Reg2Loc = 1'b1;
                    ALUOp   = ALUOP_PASSB;
                    PCWrite = 1'b1;
                    PCSrc   = (r_class == CL_B) || (r_class == CL_CBZ && Zero) ||
                              (r_class == CL_CBNZ && !Zero);
                end
                SKIP: PCWrite = 1'b1;
`ifdef MAINDEC_EXC_EN
                EXC: exc = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign instr_count = r_count;
    assign state_o     = r_state;
endmodule

// File: tb/tb_maindec_mc.sv
// tb_maindec_mc: scoreboard bench for maindec_mc; per-instruction expectations come
// from a class/latency model and are checked by a monitor when PCWrite fires.
module tb_maindec_mc;
    localparam int K_INV = 0, K_R = 1, K_ADDI = 2, K_LD = 3, K_ST = 4,
                   K_CBZ = 5, K_CBNZ = 6, K_B = 7, K_MOVZ = 8;
    localparam logic [10:0] ADD = 11'b10001011000, LDUR = 11'b11111000010,
                            STUR = 11'b11111000000, CBZ = 11'b10110100000,
                            CBNZ = 11'b10110101000, BR = 11'b00010100000,
                            ADDI = 11'b10010001000;

    logic clk = 1'b0, reset = 1'b0;
    logic [10:0] Op = '0;
    logic Zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, imem_req;
    logic [1:0] ALUOp;
    logic [31:0] instr_count;
    logic [3:0] state_o;
    logic [11:0] outs;
`ifdef MAINDEC_EXC_EN
    logic exc;
`endif

    always #5 clk = ~clk;

    maindec_mc dut (
        .clk(clk), .reset(reset), .Op(Op), .Zero(Zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .Reg2Loc(Reg2Loc),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .ALUOp(ALUOp), .imem_req(imem_req), .instr_count(instr_count),
`ifdef MAINDEC_EXC_EN
        .exc(exc),
`endif
        .state_o(state_o)
    );

    assign outs = {IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemtoReg, RegWrite,
                   MemRead, MemWrite, ALUOp, imem_req};

    typedef struct {
        bit pcsrc;
        bit regw;
        bit m2r;
        int lat;
        int mrd;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int errors = 0, checks = 0;
    bit mon_en = 1'b0;
    logic [31:0] m_cnt = '0;

    task automatic chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int kind(logic [10:0] op);
        if (op == ADD || op == 11'b11001011000 || op == 11'b10001010000 || op == 11'b10101010000) return K_R;
        if (op[10:1] == 10'b1001000100) return K_ADDI;
        if (op == LDUR) return K_LD;
        if (op == STUR) return K_ST;
        if (op[10:3] == 8'b10110100) return K_CBZ;
        if (op[10:3] == 8'b10110101) return K_CBNZ;
        if (op[10:5] == 6'b000101) return K_B;
        if (op[10:2] == 9'b110100101) return K_MOVZ;
        return K_INV;
    endfunction

    function automatic logic [10:0] rand_op();
        logic [10:0] r = 11'($urandom);
        case ($urandom_range(0, 11))
            0: return ADD;
            1: return 11'b11001011000;
            2: return 11'b10001010000;
            3: return 11'b10101010000;
            4: return {10'b1001000100, r[0]};
            5: return LDUR;
            6: return STUR;
            7: return {8'b10110100, r[2:0]};
            8: return {8'b10110101, r[2:0]};
            9: return {6'b000101, r[4:0]};
            10: return {9'b110100101, r[1:0]};
            default: return r;
        endcase
    endfunction

    // Issue one instruction: push its expectation, then drive the ready handshakes
    task automatic run_instr(logic [10:0] op, bit z, int wi, int wd);
        int k = kind(op);
        bit mem = (k == K_LD) || (k == K_ST);
        exp_t e;
        logic ri, rd;
        if (!mem) wd = 0;
        e.lat   = ((k == K_LD) ? 5 : (k == K_R || k == K_ADDI || k == K_MOVZ || k == K_ST) ? 4 : 3) + wi + wd;
        e.pcsrc = (k == K_B) || (k == K_CBZ && z) || (k == K_CBNZ && !z);
        e.regw  = (k == K_R) || (k == K_ADDI) || (k == K_MOVZ) || (k == K_LD);
        e.m2r   = (k == K_LD);
        e.mrd   = (k == K_LD) ? wd + 1 : 0;
        e.cnt   = m_cnt;
        q.push_back(e);
        if (k != K_INV) m_cnt++;
        Op = op;
        Zero = z;
        for (int c = 0; c < e.lat; c++) begin
            ri = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            imem_ready = (c < wi) ? 1'b0 : (c == wi) ? 1'b1 : ri;
            dmem_ready = (mem && c >= wi + 3 && c < wi + 3 + wd) ? 1'b0 :
                         (mem && c == wi + 3 + wd) ? 1'b1 : rd;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : monitor
        int cyc = 0, mrd = 0, irw = 0;
        bit both = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                cyc = 0; mrd = 0; irw = 0; both = 1'b0;
            end else begin
                cyc++;
                if (MemRead) mrd++;
                if (IRWrite) irw++;
                if (MemRead && MemWrite) both = 1'b1;
                if (PCWrite) begin
                    if (q.size() == 0) chk("unexpected_pcwrite", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("latency", cyc, e.lat);
                        chk("pcsrc", PCSrc, e.pcsrc);
                        chk("regwrite", RegWrite, e.regw);
                        chk("memtoreg", MemtoReg, e.m2r);
                        chk("memread_cycles", mrd, e.mrd);
                        chk("irwrite_once", irw, 1);
                        chk("count_before_retire", instr_count, e.cnt);
                        chk("rd_wr_exclusive", both, 0);
                    end
                    cyc = 0; mrd = 0; irw = 0; both = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [10:0] op;
        #23;
        chk("reset_outs", outs, 0);
        chk("reset_count", instr_count, 0);
        chk("reset_state", state_o, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("release_imem_req", imem_req, 1);
        mon_en = 1'b1;
        run_instr(ADD, 1'b0, 0, 0);
        run_instr(LDUR, 1'b0, 0, 0);
        run_instr(STUR, 1'b0, 0, 0);
        run_instr(CBZ, 1'b1, 0, 0);
        chk("program_count", instr_count, 4);
        run_instr(CBZ, 1'b0, 0, 0);
        run_instr(CBNZ, 1'b1, 0, 0);
        run_instr(CBNZ, 1'b0, 0, 0);
        run_instr(BR, 1'b0, 0, 0);
        run_instr(LDUR, 1'b0, 0, 3);
        run_instr(ADD, 1'b0, 3, 0);
        run_instr(STUR, 1'b1, 2, 2);
`ifndef MAINDEC_EXC_EN
        run_instr(11'h7FF, 1'b0, 0, 0);
        run_instr(ADD, 1'b0, 0, 0);
`endif
        for (int i = 0; i < 200; i++) begin
            op = rand_op();
`ifdef MAINDEC_EXC_EN
            if (kind(op) == K_INV) op = ADD;
`endif
            run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        chk("scoreboard_drained", q.size(), 0);

        mon_en = 1'b0;
        imem_ready = 1'b0;
        force dut.r_count = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.r_count;
        chk("forced_count", instr_count, 32'hFFFF_FFFF);
        m_cnt = 32'hFFFF_FFFF;
        mon_en = 1'b1;
        run_instr(ADDI, 1'b0, 0, 0);
        chk("count_wrap", instr_count, 0);

        mon_en = 1'b0;
        Op = LDUR;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("memrd_before_reset", MemRead, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_outs", outs, 0);
        chk("async_reset_count", instr_count, 0);
        chk("async_reset_state", state_o, 0);
        imem_ready = 1'b0;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("after_reset_imem_req", imem_req, 1);
        chk("after_reset_state", state_o, 0);
        m_cnt = '0;
        mon_en = 1'b1;
        run_instr(ADD, 1'b0, 1, 0);
        chk("scoreboard_drained_end", q.size(), 0);

`ifdef MAINDEC_EXC_EN
        mon_en = 1'b0;
        Op = 11'h7FF;
        imem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("exc_state", state_o, 8);
        for (int i = 0; i < 11; i++) begin
            chk("exc_flag", exc, 1);
            chk("exc_no_pcwrite", PCWrite, 0);
            @(posedge clk); #1;
        end
        chk("exc_state_held", state_o, 8);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
